// File: rtl/alu_seq_param.sv
// alu_seq_param: registered, parametrised ALU with valid/ready handshakes.
// Single-cycle ops (ADD, SUB, CMP, AND, OR, XOR) complete one clock after
// accept. The unsigned multiply runs WIDTH shift-add steps and then
// registers the product, so its latency is WIDTH+1 clocks.
module alu_seq_param #(
   parameter int WIDTH  = 4,
   parameter bit MUL_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic [3:0]         flags,
   output logic               err
);

   localparam int RW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_reg;
   state_t            state_next;

   logic [RW-1:0]     result_reg;
   logic [3:0]        flags_reg;
   logic              err_reg;

   // Multiplier working registers
   logic [RW-1:0]     acc_reg;
   logic [RW-1:0]     mcand_reg;
   logic [WIDTH-1:0]  mplier_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic              accept;
   logic              mul_legal;
   logic              is_mul;
   logic [RW-1:0]     single_res;
   logic [3:0]        single_flags;
   logic              single_err;

   logic [WIDTH:0]    add_sum;
   logic [WIDTH:0]    sub_sum;
   logic              add_ovf;
   logic              sub_ovf;

   // Op 110 decodes as a multiply only when the multiplier is built in
   generate
      if (MUL_EN) begin : g_mul_on
         assign mul_legal = 1'b1;
      end else begin : g_mul_off
         assign mul_legal = 1'b0;
      end
   endgenerate

   assign in_ready  = rst_n & ((state_reg == IDLE) | ((state_reg == DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_reg == DONE);
   assign result    = result_reg;
   assign flags     = flags_reg;
   assign err       = err_reg;

   assign add_sum = {1'b0, a} + {1'b0, b};
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   // Signed overflow: same-sign inputs (ADD) or different-sign inputs (SUB)
   // producing a result whose sign differs from a
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (add_sum[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (sub_sum[WIDTH-1] != a[WIDTH-1]);

   // Decode op and compute the single-cycle result and flags {C,V,N,Z}
   always_comb begin
      single_res   = '0;
      single_flags = '0;
      single_err   = 1'b0;
      is_mul       = 1'b0;
      case (op)
         3'b000: begin
            single_res[WIDTH:0] = add_sum;
            single_flags = {add_sum[WIDTH], add_ovf, add_sum[WIDTH-1],
                            (add_sum[WIDTH-1:0] == '0)};
         end
         3'b001: begin
            single_res[WIDTH:0] = sub_sum;
            single_flags = {sub_sum[WIDTH], sub_ovf, sub_sum[WIDTH-1],
                            (sub_sum[WIDTH-1:0] == '0)};
         end
         3'b010: begin
            single_res[2:0] = {(a > b), (a == b), (a < b)};
            single_flags[0] = (single_res[WIDTH-1:0] == '0);
         end
         3'b011: begin
            single_res[WIDTH-1:0] = a & b;
            single_flags = {2'b00, single_res[WIDTH-1], (single_res[WIDTH-1:0] == '0)};
         end
         3'b100: begin
            single_res[WIDTH-1:0] = a | b;
            single_flags = {2'b00, single_res[WIDTH-1], (single_res[WIDTH-1:0] == '0)};
         end
         3'b101: begin
            single_res[WIDTH-1:0] = a ^ b;
            single_flags = {2'b00, single_res[WIDTH-1], (single_res[WIDTH-1:0] == '0)};
         end
         3'b110: begin
            if (mul_legal) begin
               is_mul = 1'b1;
            end else begin
               single_err = 1'b1;
            end
         end
         default: begin
            single_err = 1'b1;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic; DONE can reload directly for back-to-back issue
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = is_mul ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (cnt_reg == CNT_W'(WIDTH)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (accept) begin
               state_next = is_mul ? BUSY : DONE;
            end else if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: load on accept, step the multiplier in BUSY, then register
   // the product on the extra cycle after the last step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_reg <= '0;
         flags_reg  <= '0;
         err_reg    <= 1'b0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
      end else if (accept) begin
         if (is_mul) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            cnt_reg    <= '0;
         end else begin
            result_reg <= single_res;
            flags_reg  <= single_flags;
            err_reg    <= single_err;
         end
      end else if (state_reg == BUSY) begin
         if (cnt_reg == CNT_W'(WIDTH)) begin
            result_reg <= acc_reg;
            flags_reg  <= {2'b00, acc_reg[RW-1], (acc_reg == '0)};
            err_reg    <= 1'b0;
         end else begin
            if (mplier_reg[0]) begin
               acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed-vector bench for alu_seq_param at WIDTH=4, MUL_EN=1.
module tb_alu_seq_param;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [3:0] flags;
   logic       err;

   int errors;
   int checks;

   alu_seq_param #(.WIDTH(4), .MUL_EN(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one op for a single accept edge (caller ensures in_ready is high)
   task automatic send(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
      checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
      rst_n = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_idle: got %b expected 1", in_ready); end
      $display("reset: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      send(3'b000, 4'd9, 4'd8);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
      checks++; if (result !== 8'h11) begin errors++; $display("FAIL add_result: got %h expected 11", result); end
      checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL add_flags: got %b expected 1100", flags); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err: got %b expected 0", err); end
      $display("add 9+8: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_sub();
      send(3'b001, 4'd3, 4'd5);
      checks++; if (result !== 8'h0E) begin errors++; $display("FAIL sub35_result: got %h expected 0e", result); end
      checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL sub35_flags: got %b expected 0010", flags); end
      $display("sub 3-5: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
      send(3'b001, 4'd5, 4'd5);
      checks++; if (result !== 8'h10) begin errors++; $display("FAIL sub55_result: got %h expected 10", result); end
      checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL sub55_flags: got %b expected 1001", flags); end
      $display("sub 5-5: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
   endtask

   task automatic test_cmp_logic();
      send(3'b010, 4'd7, 4'd7);
      checks++; if (result !== 8'h02) begin errors++; $display("FAIL cmp77_result: got %h expected 02", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL cmp77_flags: got %b expected 0000", flags); end
      $display("cmp 7,7: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
      send(3'b010, 4'd2, 4'd9);
      checks++; if (result !== 8'h01) begin errors++; $display("FAIL cmp29_result: got %h expected 01", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL cmp29_flags: got %b expected 0000", flags); end
      $display("cmp 2,9: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
      send(3'b010, 4'd9, 4'd2);
      checks++; if (result !== 8'h04) begin errors++; $display("FAIL cmp92_result: got %h expected 04", result); end
      $display("cmp 9,2: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
      send(3'b101, 4'hC, 4'hA);
      checks++; if (result !== 8'h06) begin errors++; $display("FAIL xor_result: got %h expected 06", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL xor_flags: got %b expected 0000", flags); end
      $display("xor c,a: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      send(3'b110, 4'd15, 4'd15);
      // Inputs change during BUSY and must be ignored
      a = 4'd0; b = 4'd1; op = 3'b000;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_busy_valid[%0d]: got %b expected 0", i, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_ready[%0d]: got %b expected 0", i, in_ready); end
         @(posedge clk); #1;
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_latency: got %b expected 1", out_valid); end
      checks++; if (result !== 8'hE1) begin errors++; $display("FAIL mul_ff_result: got %h expected e1", result); end
      checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL mul_ff_flags: got %b expected 0010", flags); end
      $display("mul 15*15: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
      send(3'b110, 4'd3, 4'd5);
      repeat (5) @(posedge clk);
      #1;
      checks++; if (result !== 8'h0F || out_valid !== 1'b1) begin errors++; $display("FAIL mul_3x5: got %h/%b expected 0f/1", result, out_valid); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL mul_3x5_flags: got %b expected 0000", flags); end
      $display("mul 3*5: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
      send(3'b110, 4'd0, 4'd7);
      repeat (5) @(posedge clk);
      #1;
      checks++; if (result !== 8'h00 || flags !== 4'b0001) begin errors++; $display("FAIL mul_zero: got %h/%b expected 00/0001", result, flags); end
      $display("mul 0*7: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(3'b011, 4'hC, 4'hA);
      checks++; if (result !== 8'h08 || flags !== 4'b0010) begin errors++; $display("FAIL and_result: got %h/%b expected 08/0010", result, flags); end
      // OR waits while the AND result is held
      op = 3'b100; a = 4'hC; b = 4'hA; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid !== 1'b1 || result !== 8'h08) begin errors++; $display("FAIL hold[%0d]: got %b/%h expected 1/08", i, out_valid, result); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, in_ready); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 8'h0E) begin errors++; $display("FAIL or_stream: got %b/%h expected 1/0e", out_valid, result); end
      $display("and held then or: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      op = 3'b000; a = 4'd1; b = 4'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (result !== 8'h02 || flags !== 4'b0000) begin errors++; $display("FAIL b2b_add: got %h/%b expected 02/0000", result, flags); end
      op = 3'b001; a = 4'd2; b = 4'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (result !== 8'h11 || flags !== 4'b1000) begin errors++; $display("FAIL b2b_sub: got %h/%b expected 11/1000", result, flags); end
      $display("back-to-back add,sub: result=%h flags=%b", result, flags);
      @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      send(3'b111, 4'd3, 4'd3);
      checks++; if (err !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b/%b expected 1/1", err, out_valid); end
      checks++; if (result !== 8'h00 || flags !== 4'b0000) begin errors++; $display("FAIL illegal_result: got %h/%b expected 00/0000", result, flags); end
      $display("illegal op: err=%b result=%h", err, result);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_mul();
      send(3'b110, 4'd15, 4'd15);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0 || err !== 1'b0) begin
         errors++; $display("FAIL midmul_reset_outputs: got %b/%h/%b/%b expected 0/00/0000/0", out_valid, result, flags, err);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midmul_ready_low: got %b expected 0", in_ready); end
      rst_n = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmul_ready_idle: got %b expected 1", in_ready); end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midmul_no_result[%0d]: got %b expected 0", i, out_valid); end
      end
      $display("reset mid-mul: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_add();
      test_sub();
      test_cmp_logic();
      test_mul();
      test_backpressure();
      test_back_to_back();
      test_illegal();
      test_reset_mid_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
